// File: rtl/calc_pkg.sv
// calc_pkg: numpad key codes, sequencer states and digit decode shared by calc_sequencer.
package calc_pkg;
    localparam logic [4:0] KEY_1   = 5'b10000;
    localparam logic [4:0] KEY_4   = 5'b10001;
    localparam logic [4:0] KEY_7   = 5'b10010;
    localparam logic [4:0] KEY_0   = 5'b10011;
    localparam logic [4:0] KEY_2   = 5'b10100;
    localparam logic [4:0] KEY_5   = 5'b10101;
    localparam logic [4:0] KEY_8   = 5'b10110;
    localparam logic [4:0] KEY_3   = 5'b11000;
    localparam logic [4:0] KEY_6   = 5'b11001;
    localparam logic [4:0] KEY_9   = 5'b11010;
    localparam logic [4:0] KEY_EQ  = 5'b11100;
    localparam logic [4:0] KEY_ADD = 5'b11101;
    localparam logic [4:0] KEY_SUB = 5'b11110;
    localparam logic [4:0] KEY_MUL = 5'b11111;

    typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_EXEC, S_MUL, S_COMMIT, S_RELEASE} state_t;

    // Returns {is_digit, value}; non-digit codes give 5'b0.
    function automatic logic [4:0] digit_value(input logic [4:0] code);
        case (code)
            KEY_0:   digit_value = {1'b1, 4'd0};
            KEY_1:   digit_value = {1'b1, 4'd1};
            KEY_2:   digit_value = {1'b1, 4'd2};
            KEY_3:   digit_value = {1'b1, 4'd3};
            KEY_4:   digit_value = {1'b1, 4'd4};
            KEY_5:   digit_value = {1'b1, 4'd5};
            KEY_6:   digit_value = {1'b1, 4'd6};
            KEY_7:   digit_value = {1'b1, 4'd7};
            KEY_8:   digit_value = {1'b1, 4'd8};
            KEY_9:   digit_value = {1'b1, 4'd9};
            default: digit_value = 5'd0;
        endcase
    endfunction
endpackage

// File: rtl/calc_sequencer_mul.sv
// seq_multiplier: WIDTH-cycle shift-add multiplier; done is high during the final step cycle.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (start) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q - CW'(1);
        end
    end
    assign done    = cnt_q == CW'(1);
    assign product = acc_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: debounces numpad codes and issues one stack operation per press;
// multiplication is delegated to a sequential shift-add unit.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COUNT_BITS  = 6,
    parameter int STACK_DEPTH = 32,
    parameter int DEBOUNCE    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4:0]            key,
    input  logic [WIDTH-1:0]      top,
    input  logic [WIDTH-1:0]      next,
    input  logic [COUNT_BITS-1:0] count,
    output logic                  push,
    output logic                  pop,
    output logic                  write,
    output logic [WIDTH-1:0]      new_value,
    output logic                  busy,
    output logic                  error
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    state_t state_q, state_d;
    logic [4:0] code_q, code_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic push_q, push_d, pop_q, pop_d, write_q, write_d;
    logic busy_q, busy_d, error_q, error_d, fresh_q, fresh_d;
    logic [WIDTH-1:0] new_value_q, new_value_d, mul_product;
    logic mul_start, mul_done;
    logic [4:0] dv;
    logic few, full, last;
    assign dv   = digit_value(code_q);
    assign few  = count < COUNT_BITS'(2);
    assign full = count >= COUNT_BITS'(STACK_DEPTH);
    assign last = cnt_q == DW'(DEBOUNCE - 1);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clock(clock), .reset(reset), .start(mul_start),
        .a(next), .b(top), .done(mul_done), .product(mul_product)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            cnt_q       <= '0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            write_q     <= 1'b0;
            new_value_q <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            fresh_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            write_q     <= write_d;
            new_value_q <= new_value_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            fresh_q     <= fresh_d;
        end
    end

    // The same counter times press stability and release stability.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (key[4]) begin
                state_d = S_DEBOUNCE;
                code_d  = key;
                cnt_d   = '0;
            end
            S_DEBOUNCE: begin
                if (key != code_q) state_d = S_IDLE;
                else if (last) state_d = S_EXEC;
                else cnt_d = cnt_q + DW'(1);
            end
            S_EXEC: begin
                state_d = (code_q == KEY_MUL && !few) ? S_MUL : S_RELEASE;
                cnt_d   = '0;
            end
            S_MUL: if (mul_done) state_d = S_COMMIT;
            S_COMMIT: state_d = S_RELEASE;
            S_RELEASE: begin
                if (key[4]) cnt_d = '0;
                else if (last) state_d = S_IDLE;
                else cnt_d = cnt_q + DW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push_d      = 1'b0;
        pop_d       = 1'b0;
        write_d     = 1'b0;
        new_value_d = new_value_q;
        fresh_d     = fresh_q;
        error_d     = error_q;
        mul_start   = 1'b0;
        busy_d      = state_d inside {S_EXEC, S_MUL, S_COMMIT, S_RELEASE};
        if (state_q == S_EXEC) begin
            if (dv[4]) begin
                write_d     = 1'b1;
                new_value_d = fresh_q ? WIDTH'(dv[3:0]) : top * WIDTH'(10) + WIDTH'(dv[3:0]);
                fresh_d     = 1'b0;
                error_d     = 1'b0;
            end else if (code_q == KEY_EQ) begin
                if (full) error_d = 1'b1;
                else begin
                    push_d  = 1'b1;
                    fresh_d = 1'b1;
                end
            end else if (code_q == KEY_ADD || code_q == KEY_SUB) begin
                if (few) error_d = 1'b1;
                else begin
                    pop_d       = 1'b1;
                    write_d     = 1'b1;
                    new_value_d = code_q == KEY_ADD ? next + top : next - top;
                    fresh_d     = 1'b1;
                end
            end else if (code_q == KEY_MUL) begin
                if (few) error_d = 1'b1;
                else mul_start = 1'b1;
            end
        end
        if (state_q == S_COMMIT) begin
            pop_d       = 1'b1;
            write_d     = 1'b1;
            new_value_d = mul_product;
            fresh_d     = 1'b1;
        end
    end

    assign push      = push_q;
    assign pop       = pop_q;
    assign write     = write_q;
    assign new_value = new_value_q;
    assign busy      = busy_q;
    assign error     = error_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed and random presses against a stack/key-map reference model.
module tb_calc_sequencer;
    import calc_pkg::*;
    localparam int W = 32;
    localparam int D = 4;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [4:0] key = 5'b0;
    logic [31:0] top = 32'd0, next = 32'd0;
    logic [5:0] count = 6'd0;
    logic push, pop, write, busy, error;
    logic [31:0] new_value;

    calc_sequencer #(.WIDTH(W), .COUNT_BITS(6), .STACK_DEPTH(32), .DEBOUNCE(D)) dut (
        .clock(clock), .reset(reset), .key(key), .top(top), .next(next), .count(count),
        .push(push), .pop(pop), .write(write), .new_value(new_value), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0;
    logic [31:0] stk[$];
    logic m_fresh = 1'b1, m_err = 1'b0;
    logic [2:0] e_vec;
    logic [31:0] e_val;
    int e_lat;
    int nstb, first, cyc;
    logic [2:0] r_vec;
    logic [31:0] r_val;
    logic busy_ok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_stack();
        int sz = stk.size();
        count = 6'(sz);
        top   = sz > 0 ? stk[sz-1] : 32'd0;
        next  = sz > 1 ? stk[sz-2] : 32'd0;
    endtask

    // Key map: 0..9 digits, 10 '=', 11 '+', 12 '-', 13 '*', -1 ignored.
    function automatic int kind_of(input logic [4:0] c);
        case (c)
            5'b10000: return 1;
            5'b10001: return 4;
            5'b10010: return 7;
            5'b10011: return 0;
            5'b10100: return 2;
            5'b10101: return 5;
            5'b10110: return 8;
            5'b11000: return 3;
            5'b11001: return 6;
            5'b11010: return 9;
            5'b11100: return 10;
            5'b11101: return 11;
            5'b11110: return 12;
            5'b11111: return 13;
            default:  return -1;
        endcase
    endfunction

    task automatic model(input logic [4:0] c);
        int k = kind_of(c);
        int sz = stk.size();
        logic [31:0] t = sz > 0 ? stk[sz-1] : 32'd0;
        logic [31:0] n = sz > 1 ? stk[sz-2] : 32'd0;
        e_vec = 3'b000;
        e_val = 32'd0;
        e_lat = D + 1;
        if (k >= 0 && k <= 9) begin
            e_vec = 3'b001;
            e_val = m_fresh ? 32'(k) : t * 32'd10 + 32'(k);
            m_fresh = 1'b0;
            m_err = 1'b0;
        end else if (k == 10) begin
            if (sz >= 32) m_err = 1'b1;
            else begin
                e_vec = 3'b100;
                m_fresh = 1'b1;
            end
        end else if (k >= 11) begin
            if (sz < 2) m_err = 1'b1;
            else begin
                e_vec = 3'b011;
                m_fresh = 1'b1;
                e_val = k == 11 ? n + t : k == 12 ? n - t : n * t;
                if (k == 13) e_lat = D + W + 2;
            end
        end
    endtask

    task automatic clear_rec();
        nstb = 0;
        first = -1;
        cyc = 0;
        r_vec = 3'b0;
        r_val = 32'd0;
        busy_ok = 1'b1;
    endtask

    // Acts as the operand stack: applies each observed strobe to stk.
    task automatic run(input logic [4:0] c, input int n);
        key = c;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (push || pop || write) begin
                nstb++;
                if (first < 0) first = cyc;
                r_vec = {push, pop, write};
                r_val = new_value;
                if (push) stk.push_back(stk.size() > 0 ? stk[stk.size()-1] : 32'd0);
                if (pop && stk.size() > 0) void'(stk.pop_back());
                if (write) begin
                    if (stk.size() > 0) stk[stk.size()-1] = new_value;
                    else stk.push_back(new_value);
                end
                drive_stack();
            end
            if (first >= 0 && c != 5'b0 && !busy) busy_ok = 1'b0;
            cyc++;
        end
    endtask

    task automatic finish_checks(input string tag);
        chk({tag, ":strobes"}, nstb, e_vec != 3'b0 ? 1 : 0);
        if (e_vec != 3'b0) begin
            chk({tag, ":ppw"}, r_vec, e_vec);
            if (e_vec[0]) chk({tag, ":value"}, r_val, e_val);
            chk({tag, ":latency"}, first, e_lat);
            chk({tag, ":busy_held"}, busy_ok, 1'b1);
        end
        chk({tag, ":error"}, error, m_err);
        chk({tag, ":busy_idle"}, busy, 1'b0);
    endtask

    task automatic press(input logic [4:0] c, input int hold, input string tag);
        model(c);
        clear_rec();
        run(c, hold);
        run(5'b0, 8);
        finish_checks(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        stk = '{32'd0};
        drive_stack();
        repeat (3) @(posedge clock);
        #1;
        chk("rst:push", push, 1'b0);
        chk("rst:pop", pop, 1'b0);
        chk("rst:write", write, 1'b0);
        chk("rst:value", new_value, 32'd0);
        chk("rst:busy", busy, 1'b0);
        chk("rst:error", error, 1'b0);
        reset = 1'b0;
        run(5'b0, 3);

        press(KEY_1, 45, "d1");
        press(KEY_2, 45, "d12");
        press(KEY_3, 45, "d123");
        chk("d123:stack", stk[stk.size()-1], 32'd123);

        stk = '{32'd7};
        drive_stack();
        press(KEY_EQ, 45, "eq");
        press(KEY_5, 45, "fresh5");

        stk = '{32'd10, 32'd3};
        drive_stack();
        press(KEY_SUB, 45, "sub7");
        stk = '{32'd3, 32'd10};
        drive_stack();
        press(KEY_SUB, 45, "subneg");

        stk = '{32'd1234, 32'd5678};
        drive_stack();
        press(KEY_MUL, 45, "mul");
        chk("mul:stack", stk[stk.size()-1], 32'd7006652);

        stk = '{32'd9};
        drive_stack();
        press(KEY_ADD, 45, "add_under");
        press(KEY_4, 45, "d4_clear");

        stk = '{32'd0};
        drive_stack();
        model(KEY_2);
        clear_rec();
        repeat (3) begin
            run(KEY_2, 3);
            run(5'b0, 3);
        end
        run(KEY_2, 10);
        run(5'b0, 8);
        chk("bounce:strobes", nstb, 1);
        chk("bounce:ppw", r_vec, e_vec);
        chk("bounce:value", r_val, e_val);

        press(KEY_5, 1000, "hold");
        press(5'b10111, 45, "ign1");
        press(5'b11011, 45, "ign2");

        stk.delete();
        for (int i = 0; i < 31; i++) stk.push_back(32'(i));
        drive_stack();
        press(KEY_EQ, 45, "eq31");
        press(KEY_EQ, 45, "eq_full");
        press(KEY_7, 45, "d7_clear");

        stk = '{32'd6, 32'd7};
        drive_stack();
        clear_rec();
        run(KEY_MUL, 20);
        reset = 1'b1;
        #1;
        chk("abort:busy", busy, 1'b0);
        chk("abort:write", write, 1'b0);
        chk("abort:value", new_value, 32'd0);
        key = 5'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_fresh = 1'b1;
        m_err = 1'b0;
        run(5'b0, 45);
        chk("abort:strobes", nstb, 0);
        chk("abort:error", error, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int sz = $urandom_range(0, 3);
            stk.delete();
            for (int j = 0; j < sz; j++)
                stk.push_back($urandom_range(0, 3) == 0 ? 32'($urandom) : 32'($urandom_range(0, 100)));
            drive_stack();
            press(5'(16 + $urandom_range(0, 15)), 45, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sits between the numpad scanner and the operand stack. Debounces the raw 5-bit key code and turns each physical press into exactly one stack operation: digit entry, push, add, subtract or multiply. Multiplication runs on an internal multi-cycle shift-add unit instead of a combinational multiplier. Reports underflow and overflow of the stack as a sticky error for the display.

Parameters:
WIDTH, 32, datapath width of stack entries and new_value
COUNT_BITS, 6, width of the stack occupancy count
STACK_DEPTH, 32, maximum entries; push at this count is refused
DEBOUNCE, 16, consecutive stable cycles required to accept a press or a release

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
key  input  5  raw numpad code; bit4=1 means a key is held, 5'b0xxxx means none
top  input  WIDTH  current stack top
next  input  WIDTH  entry below top
count  input  COUNT_BITS  stack occupancy
push  output  1  one-cycle strobe: duplicate top onto stack
pop  output  1  one-cycle strobe: remove top (paired with write for binary ops)
write  output  1  one-cycle strobe: overwrite top (after pop, if pop is set) with new_value
new_value  output  WIDTH  value for write; valid only when write=1
busy  output  1  high from press acceptance until release is accepted
error  output  1  sticky: last operation refused

Behaviour:
- Reset (async): state IDLE; push/pop/write=0; new_value=0; busy=0; error=0; fresh=1; debounce counter=0.
- Key map: 10000=1, 10001=4, 10010=7, 10011=0, 10100=2, 10101=5, 10110=8, 11000=3, 11001=6, 11010=9, 11100='=' (push), 11101=+, 11110=-, 11111=*. Codes 10111 and 11011 are ignored (no op, no error).
- States: IDLE, DEBOUNCE, EXEC, MUL, COMMIT, RELEASE.
- IDLE: when key[4]=1, latch the code, clear the counter and go to DEBOUNCE.
- DEBOUNCE: if key differs from the latched code, return to IDLE. After DEBOUNCE consecutive equal cycles, go to EXEC and raise busy.
- EXEC (one cycle) decodes the latched code:
  - Digit d: write=1. new_value = d if fresh=1, else (top*10+d) mod 2^WIDTH. Then fresh=0 and error is cleared. Go to RELEASE.
  - '=': if count>=STACK_DEPTH, error=1 and no strobe. Otherwise push=1 and fresh=1. Go to RELEASE.
  - '+' or '-': if count<2, error=1 and no strobe. Otherwise pop=1, write=1, new_value = next±top mod 2^WIDTH (two's complement wrap), fresh=1. Go to RELEASE.
  - '*': if count<2, error=1 and go to RELEASE. Otherwise latch A=next and B=top, clear the accumulator and go to MUL.
  - Ignored code: go to RELEASE.
- MUL: exactly WIDTH cycles. Each cycle: if B[0]=1, acc+=A; then A<<=1 and B>>=1. The result is the low WIDTH bits. Then go to COMMIT.
- COMMIT (one cycle): pop=1, write=1, new_value=acc, fresh=1. Go to RELEASE.
- Strobes are registered and high for exactly one cycle per accepted press. pop and write are coincident for binary ops.
- Press-to-strobe latency from the first stable cycle: DEBOUNCE+1 cycles for digit/+/-/=, and DEBOUNCE+WIDTH+2 cycles for '*'.
- RELEASE: requires key[4]=0 for DEBOUNCE consecutive cycles; any held cycle restarts the count. Then go to IDLE and drop busy. A held key never repeats.
- A key change during MUL is ignored; the operation completes.
- Reset asserted mid-MUL aborts the operation and issues no strobe.
- Error stays set until the next accepted digit. Push and binary ops do not clear it.
- top, next and count are sampled in EXEC only. The stack must be stable while busy.

Decomposition:
- Shared package calc_pkg: key code constants (KEY_0..KEY_9, KEY_EQ, KEY_ADD, KEY_SUB, KEY_MUL), state encoding, and a digit-value decode function.
- One sub-module: seq_multiplier (start, a, b → done, product), a WIDTH-cycle shift-add unit with asynchronous reset.

Test Plan:
All scenarios use DEBOUNCE=4 and WIDTH=32.
- After reset, press 1, 2, 3 with releases, stack model count=1 → three single-cycle writes with new_value 1, 12, 123. Never push or pop.
- top=7, count=1: press '=' then 5 → one push strobe, then write new_value=5 (fresh entry, not 75).
- next=10, top=3, count=2: press '-' → pop=write=1 in the same cycle, new_value=7. With next=3, top=10: new_value=32'hFFFFFFF9.
- next=1234, top=5678, count=2: press '*' → no strobe for 33 cycles after EXEC, then pop+write with new_value=7006652. busy stays high through release.
- count=1: press '+' → no strobes, error=1. Press 4 → write new_value=4, error=0.
- Key bounces 10100/00000 for 3-cycle bursts, then holds 10 cycles → exactly one write. Holding the key for 1000 cycles produces no second strobe.
